// File: rtl/wb_regfile.sv
// Writeback stage: final write-data mux, 32x32 GPR file with same-cycle
// write-through read bypass, retired-instruction counter and last-commit record.
module wb_regfile #(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] LINK_OFS = 32'd8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidW,
    input  logic             RegWriteW,
    input  logic [1:0]       WDSelW,
    input  logic [2:0]       MemOpW,
    input  logic [WIDTH-1:0] MDM,
    input  logic [WIDTH-1:0] AOM,
    input  logic [4:0]       WAM,
    input  logic [WIDTH-1:0] PCM,
    input  logic [4:0]       RA1D,
    input  logic [4:0]       RA2D,
    output logic [WIDTH-1:0] RD1D,
    output logic [WIDTH-1:0] RD2D,
    output logic [WIDTH-1:0] WDW,
    output logic             WEW,
    output logic [WIDTH-1:0] RetireCnt,
    output logic [4:0]       LastWAW,
    output logic [WIDTH-1:0] LastWDW,
    output logic [WIDTH-1:0] LastPCW
);

    // Little-endian sub-word selection; misaligned low address bits are ignored.
    function automatic logic [31:0] load_extend(input logic [2:0]  op,
                                                input logic [1:0]  addr,
                                                input logic [31:0] word);
        logic [15:0] half_v;
        logic [7:0]  byte_v;
        logic [31:0] res_v;
        half_v = addr[1] ? word[31:16] : word[15:0];
        case (addr)
            2'b00:   byte_v = word[7:0];
            2'b01:   byte_v = word[15:8];
            2'b10:   byte_v = word[23:16];
            2'b11:   byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        case (op)
            3'b001:  res_v = {{16{half_v[15]}}, half_v};
            3'b010:  res_v = {16'h0000, half_v};
            3'b011:  res_v = {{24{byte_v[7]}}, byte_v};
            3'b100:  res_v = {24'h000000, byte_v};
            default: res_v = word;
        endcase
        return res_v;
    endfunction

    logic [31:0] regs_r [0:31];
    logic [31:0] wdw_s;
    logic        wew_s;
    logic [31:0] rd1_s;
    logic [31:0] rd2_s;
    logic [31:0] retire_cnt_r;
    logic [4:0]  last_wa_r;
    logic [31:0] last_wd_r;
    logic [31:0] last_pc_r;

    // Write-back data select and effective write enable.
    always_comb begin
        wdw_s = AOM;
        case (WDSelW)
            2'b01:   wdw_s = load_extend(MemOpW, AOM[1:0], MDM);
            2'b10:   wdw_s = PCM + LINK_OFS;
            default: wdw_s = AOM;
        endcase
        wew_s = ValidW & RegWriteW & (WAM != 5'd0);
    end

    // Read ports: r0 hardwired to zero, then bypass of the in-flight write.
    always_comb begin
        rd1_s = 32'h0000_0000;
        rd2_s = 32'h0000_0000;
        if (RA1D == 5'd0) begin
            rd1_s = 32'h0000_0000;
        end else if (wew_s && (RA1D == WAM)) begin
            rd1_s = wdw_s;
        end else begin
            rd1_s = regs_r[RA1D];
        end
        if (RA2D == 5'd0) begin
            rd2_s = 32'h0000_0000;
        end else if (wew_s && (RA2D == WAM)) begin
            rd2_s = wdw_s;
        end else begin
            rd2_s = regs_r[RA2D];
        end
    end

    // Register file commit; entry 0 is never written because wew_s excludes r0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else if (wew_s) begin
            regs_r[WAM] <= wdw_s;
        end
    end

    // Retire counter and last-commit trace record.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_cnt_r <= 32'h0000_0000;
            last_wa_r    <= 5'd0;
            last_wd_r    <= 32'h0000_0000;
            last_pc_r    <= 32'h0000_0000;
        end else begin
            if (ValidW) begin
                retire_cnt_r <= retire_cnt_r + 32'd1;
            end
            if (wew_s) begin
                last_wa_r <= WAM;
                last_wd_r <= wdw_s;
                last_pc_r <= PCM;
            end
        end
    end

    assign WDW       = wdw_s;
    assign WEW       = wew_s;
    assign RD1D      = rd1_s;
    assign RD2D      = rd2_s;
    assign RetireCnt = retire_cnt_r;
    assign LastWAW   = last_wa_r;
    assign LastWDW   = last_wd_r;
    assign LastPCW   = last_pc_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic against an array-based reference model of the commit stage.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        ValidW, RegWriteW;
    logic [1:0]  WDSelW;
    logic [2:0]  MemOpW;
    logic [31:0] MDM, AOM, PCM;
    logic [4:0]  WAM, RA1D, RA2D;
    logic [31:0] RD1D, RD2D, WDW;
    logic        WEW;
    logic [31:0] RetireCnt;
    logic [4:0]  LastWAW;
    logic [31:0] LastWDW, LastPCW;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] m_regs [0:31];
    logic [31:0] m_cnt;
    logic [4:0]  m_lwa;
    logic [31:0] m_lwd, m_lpc;

    wb_regfile #(.WIDTH(32), .LINK_OFS(32'd8)) dut (
        .clk(clk), .reset(reset), .ValidW(ValidW), .RegWriteW(RegWriteW),
        .WDSelW(WDSelW), .MemOpW(MemOpW), .MDM(MDM), .AOM(AOM), .WAM(WAM),
        .PCM(PCM), .RA1D(RA1D), .RA2D(RA2D), .RD1D(RD1D), .RD2D(RD2D),
        .WDW(WDW), .WEW(WEW), .RetireCnt(RetireCnt), .LastWAW(LastWAW),
        .LastWDW(LastWDW), .LastPCW(LastPCW)
    );

    always #5 clk = ~clk;

    // Expected write-back value computed with shifts and arithmetic sign handling.
    function automatic logic [31:0] exp_wd(input logic [1:0] sel, input logic [2:0] op,
                                           input logic [31:0] mdm, input logic [31:0] aom,
                                           input logic [31:0] pcm);
        int unsigned sh;
        logic [31:0] v;
        if (sel == 2'd2) return pcm + 32'd8;
        if (sel != 2'd1) return aom;
        if (op == 3'd1 || op == 3'd2) begin
            sh = aom[1] ? 16 : 0;
            v  = (mdm >> sh) & 32'h0000_FFFF;
            if (op == 3'd1 && v >= 32'h0000_8000) v = v - 32'h0001_0000;
        end else if (op == 3'd3 || op == 3'd4) begin
            sh = 8 * int'(aom[1:0]);
            v  = (mdm >> sh) & 32'h0000_00FF;
            if (op == 3'd3 && v >= 32'h0000_0080) v = v - 32'h0000_0100;
        end else begin
            v = mdm;
        end
        return v;
    endfunction

    function automatic logic exp_we();
        return ValidW && RegWriteW && (WAM != 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
        if (exp_we() && ra == WAM) return exp_wd(WDSelW, MemOpW, MDM, AOM, PCM);
        return m_regs[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_cnt = 32'h0; m_lwa = 5'd0; m_lwd = 32'h0; m_lpc = 32'h0;
    endtask

    // Apply what the coming rising edge should commit, then advance past it.
    task automatic step();
        logic [31:0] wd;
        wd = exp_wd(WDSelW, MemOpW, MDM, AOM, PCM);
        if (reset) begin
            if (ValidW) m_cnt = m_cnt + 32'd1;
            if (exp_we()) begin
                m_regs[WAM] = wd; m_lwa = WAM; m_lwd = wd; m_lpc = PCM;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic v, input logic rw, input logic [1:0] sel,
                          input logic [2:0] op, input logic [31:0] mdm,
                          input logic [31:0] aom, input logic [4:0] wam,
                          input logic [31:0] pcm);
        ValidW = v; RegWriteW = rw; WDSelW = sel; MemOpW = op;
        MDM = mdm; AOM = aom; WAM = wam; PCM = pcm;
    endtask

    task automatic test_reset();
        n_cmp++; if (RetireCnt !== 32'h0 || LastWAW !== 5'd0 || LastWDW !== 32'h0 || LastPCW !== 32'h0) begin
            n_fail++; $display("FAIL reset_state: cnt=%h wa=%0d wd=%h pc=%h, required all 0", RetireCnt, LastWAW, LastWDW, LastPCW); end
        reset = 1'b1;
        step();
        set_in(1'b1, 1'b1, 2'b00, 3'd0, 32'h0, 32'h1111_1111, 5'd7, 32'h40);
        step();
        set_in(1'b0, 1'b0, 2'b00, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0);
        RA1D = 5'd7; #1;
        n_cmp++; if (RD1D !== 32'h1111_1111) begin
            n_fail++; $display("FAIL pre_reset_r7: got %h, required 11111111", RD1D); end
        reset = 1'b0; #1;
        model_reset();
        n_cmp++; if (RD1D !== 32'h0) begin
            n_fail++; $display("FAIL async_reset_rd: got %h, required 0", RD1D); end
        n_cmp++; if (RetireCnt !== 32'h0 || LastWAW !== 5'd0 || LastWDW !== 32'h0 || LastPCW !== 32'h0) begin
            n_fail++; $display("FAIL async_reset_state: cnt=%h wa=%0d wd=%h pc=%h, required all 0", RetireCnt, LastWAW, LastWDW, LastPCW); end
        // Bypass still live during reset, but nothing commits
        set_in(1'b1, 1'b1, 2'b00, 3'd0, 32'h0, 32'h2222_2222, 5'd7, 32'h44);
        #1;
        n_cmp++; if (RD1D !== 32'h2222_2222) begin
            n_fail++; $display("FAIL reset_bypass: got %h, required 22222222", RD1D); end
        step();
        ValidW = 1'b0; #1;
        n_cmp++; if (RD1D !== 32'h0 || RetireCnt !== 32'h0) begin
            n_fail++; $display("FAIL reset_suppress: rd=%h cnt=%h, required 0/0", RD1D, RetireCnt); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_alu_bypass();
        set_in(1'b1, 1'b1, 2'b00, 3'd0, 32'h0, 32'h1234_5678, 5'd5, 32'h0000_0100);
        RA1D = 5'd5; RA2D = 5'd5; #1;
        n_cmp++; if (RD1D !== 32'h1234_5678 || RD2D !== 32'h1234_5678 || WEW !== 1'b1) begin
            n_fail++; $display("FAIL alu_bypass: rd1=%h rd2=%h wew=%b, required 12345678/12345678/1", RD1D, RD2D, WEW); end
        step();
        RegWriteW = 1'b0; #1;
        n_cmp++; if (RD1D !== 32'h1234_5678 || RD2D !== 32'h1234_5678) begin
            n_fail++; $display("FAIL alu_stored: rd1=%h rd2=%h, required 12345678", RD1D, RD2D); end
        n_cmp++; if (RetireCnt !== 32'd1 || LastWAW !== 5'd5 || LastPCW !== 32'h100 || LastWDW !== 32'h1234_5678) begin
            n_fail++; $display("FAIL alu_record: cnt=%h wa=%0d pc=%h wd=%h, required 1/5/100/12345678", RetireCnt, LastWAW, LastPCW, LastWDW); end
        step();
    endtask

    task automatic test_load_ext();
        logic [2:0]  ops [6] = '{3'd3, 3'd4, 3'd3, 3'd1, 3'd2, 3'd0};
        logic [1:0]  ofs [6] = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd2, 2'd0};
        logic [31:0] req [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F,
                                 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};
        for (int i = 0; i < 6; i++) begin
            set_in(1'b0, 1'b0, 2'b01, ops[i], 32'h80FF_7F01, {30'h0400_0000, ofs[i]}, 5'd9, 32'h0);
            #1;
            n_cmp++; if (WDW !== req[i]) begin
                n_fail++; $display("FAIL load_ext[%0d] op=%0d ofs=%0d: got %h, required %h", i, ops[i], ofs[i], WDW, req[i]); end
        end
    endtask

    task automatic test_link();
        set_in(1'b1, 1'b1, 2'b10, 3'd0, 32'h0, 32'hABCD_0000, 5'd31, 32'h0000_3010);
        #1;
        n_cmp++; if (WDW !== 32'h0000_3018) begin
            n_fail++; $display("FAIL link_wdw: got %h, required 00003018", WDW); end
        step();
        ValidW = 1'b0; RA2D = 5'd31; #1;
        n_cmp++; if (RD2D !== 32'h0000_3018) begin
            n_fail++; $display("FAIL link_stored: got %h, required 00003018", RD2D); end
    endtask

    task automatic test_r0_bubble();
        logic [31:0] cnt0, r3;
        cnt0 = RetireCnt;
        set_in(1'b1, 1'b1, 2'b00, 3'd0, 32'h0, 32'hDEAD_BEEF, 5'd0, 32'h200);
        RA1D = 5'd0; #1;
        n_cmp++; if (WEW !== 1'b0 || RD1D !== 32'h0) begin
            n_fail++; $display("FAIL r0_write: wew=%b rd=%h, required 0/0", WEW, RD1D); end
        step();
        ValidW = 1'b0; #1;
        n_cmp++; if (RetireCnt !== cnt0 + 32'd1 || LastWAW !== 5'd31 || LastWDW !== 32'h3018 || LastPCW !== 32'h3010) begin
            n_fail++; $display("FAIL r0_record: cnt=%h wa=%0d wd=%h pc=%h", RetireCnt, LastWAW, LastWDW, LastPCW); end
        r3 = m_regs[3];
        set_in(1'b0, 1'b1, 2'b00, 3'd0, 32'h0, 32'h5555_AAAA, 5'd3, 32'h204);
        RA1D = 5'd3;
        step();
        n_cmp++; if (RD1D !== r3 || RetireCnt !== cnt0 + 32'd1) begin
            n_fail++; $display("FAIL bubble: rd3=%h cnt=%h, required %h/%h", RD1D, RetireCnt, r3, cnt0 + 32'd1); end
    endtask

    task automatic test_back_to_back();
        reset = 1'b0; #1; model_reset(); reset = 1'b1;
        step();
        RA1D = 5'd4;
        for (int i = 1; i <= 3; i++) begin
            set_in(1'b1, 1'b1, 2'b00, 3'd0, 32'h0, 32'(i), 5'd4, 32'h300 + 32'(4 * i));
            #1;
            n_cmp++; if (RD1D !== 32'(i)) begin
                n_fail++; $display("FAIL b2b_bypass[%0d]: got %h, required %h", i, RD1D, 32'(i)); end
            step();
        end
        ValidW = 1'b0; #1;
        n_cmp++; if (RetireCnt !== 32'd3 || LastWDW !== 32'd3 || RD1D !== 32'd3) begin
            n_fail++; $display("FAIL b2b_final: cnt=%h lwd=%h rd=%h, required 3/3/3", RetireCnt, LastWDW, RD1D); end
    endtask

    task automatic test_random();
        logic [31:0] e;
        for (int i = 0; i < 300; i++) begin
            set_in(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                   2'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom), $urandom);
            RA1D = ($urandom_range(0, 2) == 0) ? WAM : 5'($urandom);
            RA2D = ($urandom_range(0, 3) == 0) ? RA1D : 5'($urandom);
            #1;
            e = exp_wd(WDSelW, MemOpW, MDM, AOM, PCM);
            n_cmp++; if (WDW !== e || WEW !== exp_we()) begin
                n_fail++; $display("FAIL rnd_wd[%0d]: wdw=%h wew=%b, required %h/%b", i, WDW, WEW, e, exp_we()); end
            n_cmp++; if (RD1D !== exp_rd(RA1D) || RD2D !== exp_rd(RA2D)) begin
                n_fail++; $display("FAIL rnd_rd[%0d]: rd1=%h rd2=%h, required %h/%h", i, RD1D, RD2D, exp_rd(RA1D), exp_rd(RA2D)); end
            step();
            n_cmp++; if (RetireCnt !== m_cnt || LastWAW !== m_lwa || LastWDW !== m_lwd || LastPCW !== m_lpc) begin
                n_fail++; $display("FAIL rnd_state[%0d]: cnt=%h wa=%0d wd=%h pc=%h, required %h/%0d/%h/%h",
                                   i, RetireCnt, LastWAW, LastWDW, LastPCW, m_cnt, m_lwa, m_lwd, m_lpc); end
        end
    endtask

    initial begin
        reset = 1'b0;
        set_in(1'b0, 1'b0, 2'b00, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0);
        RA1D = 5'd0; RA2D = 5'd0;
        model_reset();
        #2;
        test_reset();
        test_alu_bypass();
        test_load_ext();
        test_link();
        test_r0_bubble();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
